// File: rtl/text_overlay_engine.sv
// rtl/text_overlay_engine.sv - character-cell text overlay for the VGA pixel path
//
// Renders a COLS x ROWS character buffer at (ORIGIN_X, ORIGIN_Y), each glyph
// an 8x16 font cell scaled by 2^SCALE_LOG2. Pixel path latency is 3 cycles.
// The buffer is wiped by a clear FSM after reset and on every clr pulse.
//
// Optional build macro: TEXT_CURSOR_EN - underline the cell at
// (cur_col, cur_row) on glyph lines 14-15 while the blink phase is 0.
//
// Ports:
//   clk         pixel clock
//   reset       asynchronous active-high reset
//   x, y        current pixel column / row
//   frame_tick  one-cycle pulse per frame, drives the blink timer
//   wr_valid    character write request
//   wr_ready    write accepted when wr_valid && wr_ready
//   wr_addr     linear cell index row*COLS+col
//   wr_data     [6:0] ASCII code, [7] blink attribute
//   clr         pulse: start a buffer clear
//   busy        clear in progress
//   cur_col     cursor column (used only with TEXT_CURSOR_EN)
//   cur_row     cursor row (used only with TEXT_CURSOR_EN)
//   text_on     current pixel is lit text
//   text_rgb    FG_RGB when text_on, else 12'h000

module ascii_rom (
  input  logic        clk,
  input  logic [10:0] addr,   // {code[6:0], line[3:0]}
  output logic [7:0]  data    // registered, 1-cycle latency
);
  // Each glyph packs 16 rows of 8 pixels, line 0 in the top byte.
  localparam logic [127:0] G_0 = 128'h00007CC6C6CEDEF6E6C6C67C00000000;
  localparam logic [127:0] G_1 = 128'h00001838781818181818187E00000000;
  localparam logic [127:0] G_2 = 128'h00007CC6060C183060C0C6FE00000000;
  localparam logic [127:0] G_3 = 128'h00007CC606063C060606C67C00000000;
  localparam logic [127:0] G_4 = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
  localparam logic [127:0] G_5 = 128'h0000FEC0C0C0FC060606C67C00000000;
  localparam logic [127:0] G_6 = 128'h00003860C0C0FCC6C6C6C67C00000000;
  localparam logic [127:0] G_7 = 128'h0000FEC606060C183030303000000000;
  localparam logic [127:0] G_8 = 128'h00007CC6C6C67CC6C6C6C67C00000000;
  localparam logic [127:0] G_9 = 128'h00007CC6C6C67E0606060C7800000000;
  localparam logic [127:0] G_A = 128'h000010386CC6C6FEC6C6C6C600000000;
  localparam logic [127:0] G_P = 128'h0000FC6666667C60606060F000000000;

  // Codes without a glyph in the table (including 0x00) render blank.
  function automatic logic [7:0] glyph_row(input logic [6:0] code, input logic [3:0] line);
    logic [127:0] g;
    logic [3:0]   inv;
    case (code)
      7'h30: g = G_0;
      7'h31: g = G_1;
      7'h32: g = G_2;
      7'h33: g = G_3;
      7'h34: g = G_4;
      7'h35: g = G_5;
      7'h36: g = G_6;
      7'h37: g = G_7;
      7'h38: g = G_8;
      7'h39: g = G_9;
      7'h41: g = G_A;
      7'h50: g = G_P;
      default: g = '0;
    endcase
    inv = ~line;
    return g[{inv, 3'b000} +: 8];
  endfunction

  always_ff @(posedge clk) begin
    data <= glyph_row(addr[10:4], addr[3:0]);
  end
endmodule

module text_overlay_engine #(
  parameter int          COLS         = 40,
  parameter int          ROWS         = 4,
  parameter int          SCALE_LOG2   = 1,
  parameter int          ORIGIN_X     = 0,
  parameter int          ORIGIN_Y     = 32,
  parameter logic [11:0] FG_RGB       = 12'hFFF,
  parameter int          BLINK_FRAMES = 30,
  localparam int         AW           = $clog2(COLS * ROWS),
  localparam int         CW           = $clog2(COLS),
  localparam int         RW           = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          frame_tick,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          clr,
  output logic          busy,
  input  logic [CW-1:0] cur_col,
  input  logic [RW-1:0] cur_row,
  output logic          text_on,
  output logic [11:0]   text_rgb
);
  localparam int CELLS = COLS * ROWS;
  localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] ptr, ptr_nx;

  logic [7:0]    mem [CELLS];

  // ---------------- clear FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    busy     = 1'b0;
    wr_ready = 1'b0;
    case (state)
      CLEAR: begin
        // clr is deliberately ignored here: a clear always runs to completion.
        busy   = 1'b1;
        ptr_nx = ptr + 1'b1;
        if (ptr == AW'(CELLS - 1)) begin
          state_nx = IDLE;
          ptr_nx   = '0;
        end
      end
      IDLE: begin
        // clr beats a same-cycle write, so the write is refused immediately.
        wr_ready = !clr;
        if (clr) begin
          ptr_nx   = '0;
          state_nx = CLEAR;
        end
      end
      default: state_nx = CLEAR;
    endcase
  end

  logic wr_fire, wr_hit;
  assign wr_fire = wr_valid && wr_ready;
  assign wr_hit  = {1'b0, wr_addr} < (AW + 1)'(CELLS);

  // ---------------- blink timer ----------------
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= !blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // ---------------- pixel -> cell mapping ----------------
  logic [9:0]    dx, dy, col, row;
  logic          in_win;
  logic [AW-1:0] rd_idx;
  logic [2:0]    bit_idx;
  logic [3:0]    line;

  always_comb begin
    dx      = x - 10'(ORIGIN_X);
    dy      = y - 10'(ORIGIN_Y);
    col     = dx >> (3 + SCALE_LOG2);
    row     = dy >> (4 + SCALE_LOG2);
    bit_idx = 3'(dx >> SCALE_LOG2);
    line    = 4'(dy >> SCALE_LOG2);
    // Origin checks on the raw coordinates keep dx/dy wrap-around out.
    in_win  = (x >= 10'(ORIGIN_X)) && (y >= 10'(ORIGIN_Y)) &&
              (col < 10'(COLS)) && (row < 10'(ROWS));
    rd_idx  = in_win ? AW'(row * COLS + col) : '0;
  end

`ifdef TEXT_CURSOR_EN
  logic cur_hit;
  assign cur_hit = in_win && (col == 10'(cur_col)) && (row == 10'(cur_row)) &&
                   (line[3:1] == 3'b111);
`else
  logic unused_cursor;
  assign unused_cursor = ^{cur_col, cur_row};
`endif

  // ---------------- buffer: write port + S1 read ----------------
  // Non-blocking update means a same-cycle read sees the previous contents.
  logic [7:0] s1_cell;

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[ptr] <= 8'h00;
    end else if (wr_fire && wr_hit) begin
      mem[wr_addr] <= wr_data;
    end
    s1_cell <= mem[rd_idx];
  end

  // ---------------- pipeline S1..S3 ----------------
  logic       s1_in, s2_in, s2_blank;
  logic [2:0] s1_bit, s2_bit;
  logic [3:0] s1_line;
  logic [7:0] rom_data;
  logic       lit;
`ifdef TEXT_CURSOR_EN
  logic       s1_cur, s2_cur;
`endif

  ascii_rom u_rom (
    .clk  (clk),
    .addr ({s1_cell[6:0], s1_line}),
    .data (rom_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_in    <= 1'b0;
      s1_bit   <= '0;
      s1_line  <= '0;
      s2_in    <= 1'b0;
      s2_bit   <= '0;
      s2_blank <= 1'b0;
`ifdef TEXT_CURSOR_EN
      s1_cur   <= 1'b0;
      s2_cur   <= 1'b0;
`endif
      text_on  <= 1'b0;
      text_rgb <= 12'h000;
    end else begin
      s1_in    <= in_win;
      s1_bit   <= bit_idx;
      s1_line  <= line;
      s2_in    <= s1_in;
      s2_bit   <= s1_bit;
      s2_blank <= s1_cell[7] && blink_phase;
`ifdef TEXT_CURSOR_EN
      s1_cur   <= cur_hit;
      s2_cur   <= s1_cur && !blink_phase;
`endif
      text_on  <= lit;
      text_rgb <= lit ? FG_RGB : 12'h000;
    end
  end

  // Font bit 7 is the leftmost pixel, so index with the inverted bit number.
  always_comb begin
    lit = s2_in && rom_data[~s2_bit] && !s2_blank;
`ifdef TEXT_CURSOR_EN
    lit = lit || (s2_in && s2_cur);
`endif
  end
endmodule

// File: tb/tb_text_overlay_engine.sv
// tb/tb_text_overlay_engine.sv - scoreboard bench for text_overlay_engine
module tb_text_overlay_engine;
  localparam int COLS = 40;
  localparam int ROWS = 4;
  localparam int NC   = COLS * ROWS;
  localparam int BF   = 2;
  localparam int OY   = 32;

  localparam logic [7:0] GA [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                                     8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam logic [7:0] GP [16] = '{8'h00, 8'h00, 8'hFC, 8'h66, 8'h66, 8'h66, 8'h7C, 8'h60,
                                     8'h60, 8'h60, 8'h60, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  x = '0, y = '0;
  logic        frame_tick = 1'b0, wr_valid = 1'b0, clr = 1'b0;
  logic        wr_ready, busy, text_on;
  logic [7:0]  wr_addr = '0, wr_data = '0;
  logic [5:0]  cur_col = 6'd5;
  logic [1:0]  cur_row = 2'd1;
  logic [11:0] text_rgb;

  int total = 0;
  int bad = 0;
  int frames = 0;
  logic [7:0] model [NC];
  logic exp_q [$];

  always #5 clk = ~clk;

  text_overlay_engine #(.BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .frame_tick(frame_tick),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr(clr), .busy(busy), .cur_col(cur_col), .cur_row(cur_row),
    .text_on(text_on), .text_rgb(text_rgb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] font(input logic [6:0] c, input int ln);
    case (c)
      7'h41: return GA[ln];
      7'h50: return GP[ln];
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic exp_pixel(input int px, input int py);
    int dx, dy, col, row, ln, b;
    logic [7:0] c, f;
    logic ph, lit;
    if (px < 0 || py < OY) return 1'b0;
    dx = px; dy = py - OY;
    col = dx / 16; row = dy / 32;
    if (col >= COLS || row >= ROWS) return 1'b0;
    c = model[row * COLS + col];
    ln = (dy / 2) % 16;
    b = (dx / 2) % 8;
    ph = ((frames / BF) % 2) == 1;
    f = font(c[6:0], ln);
    lit = f[7 - b] && !(c[7] && ph);
`ifdef TEXT_CURSOR_EN
    if (col == int'(cur_col) && row == int'(cur_row) && ln >= 14 && !ph) lit = 1'b1;
`endif
    return lit;
  endfunction

  // One pixel per cycle; results pop out three cycles after they were driven.
  task automatic px_step(input string tag, input int px, input int py);
    logic e;
    @(negedge clk);
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      check({tag, "_on"}, 32'(text_on), 32'(e));
      check({tag, "_rgb"}, 32'(text_rgb), e ? 32'hFFF : 32'h0);
    end
    x = 10'(px); y = 10'(py);
    exp_q.push_back(exp_pixel(px, py));
  endtask

  task automatic sweep(input string tag, input int x0, input int x1, input int yy);
    for (int i = x0; i <= x1; i++) px_step(tag, i, yy);
    for (int i = 0; i < 3; i++) px_step(tag, 0, 0);
    exp_q.delete();
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 8'(a); wr_data = d;
    #1 check("wr_ready", 32'(wr_ready), 32'd1);
    @(posedge clk);
    #1 wr_valid = 1'b0;
    if (a < NC) model[a] = d;
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    frames++;
  endtask

  task automatic count_busy(input string tag, input bit pulse_mid);
    int n;
    int rdy_hi;
    n = 0; rdy_hi = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      if (wr_ready !== 1'b0) rdy_hi++;
      clr = pulse_mid && (n == 50);
      @(negedge clk);
    end
    clr = 1'b0;
    check({tag, "_cycles"}, 32'(n), 32'd160);
    check({tag, "_ready_low"}, 32'(rdy_hi), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_ready_after"}, 32'(wr_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NC; i++) model[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_text_on", 32'(text_on), 32'd0);
    check("rst_text_rgb", 32'(text_rgb), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    reset = 1'b0;
    count_busy("init", 1'b0);

    sweep("blank", 0, 647, OY + 6);

    wr(0, 8'h50);
    wr(40, 8'h41);
    wr(159, 8'h50);
    sweep("p_line3", 0, 15, OY + 6);
    sweep("a_row1", 0, 15, OY + 32 + 8);
    sweep("last_cell", 620, 643, OY + 96 + 6);

    sweep("oow_y31", 0, 15, OY - 1);
    sweep("oow_col40", 630, 655, OY + 6);
    sweep("oow_row4", 0, 15, OY + 128 + 6);

    wr(160, 8'h41);
    sweep("after_oob", 0, 15, OY + 6);

    wr(2, 8'hC1);
    for (int f = 0; f <= 4; f++) begin
      sweep("blink", 32, 47, OY + 10);
      if (f < 4) tick();
    end

`ifdef TEXT_CURSOR_EN
    sweep("cur_l14", 76, 99, OY + 32 + 28);
    sweep("cur_l15", 76, 99, OY + 32 + 30);
    sweep("cur_l13", 76, 99, OY + 32 + 26);
    tick();
    tick();
    sweep("cur_off", 76, 99, OY + 32 + 28);
`endif

    @(negedge clk);
    clr = 1'b1; wr_valid = 1'b1; wr_addr = 8'd3; wr_data = 8'h50;
    #1 check("clr_wr_ready", 32'(wr_ready), 32'd0);
    @(posedge clk);
    #1 clr = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NC; i++) model[i] = 8'h00;
    count_busy("reclear", 1'b1);

    sweep("clr_row0", 0, 47, OY + 10);
    sweep("clr_row1", 0, 15, OY + 32 + 8);
    sweep("clr_last", 620, 639, OY + 96 + 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/text_overlay_engine.md
Name: text_overlay_engine

Overview:
- Parametrised successor to the fixed-layout text renderer: a general character-cell overlay for the VGA pixel path.
- Game logic writes characters into an internal COLS x ROWS character buffer; the block renders that buffer at a configurable origin and integer scale.
- Reads the buffer and an internal ascii_rom (8x16 font) through a 3-stage pipeline; supports per-character blink and a bulk-clear FSM.
- Sits between the pixel-coordinate generator and the final RGB mux.

Parameters:
- COLS, 40, character columns.
- ROWS, 4, character rows.
- SCALE_LOG2, 1, glyph scale 2^SCALE_LOG2 (1 gives 16x32 cells).
- ORIGIN_X, 0, left pixel of the text window.
- ORIGIN_Y, 32, top pixel of the text window.
- FG_RGB, 12'hFFF, colour of lit glyph pixels.
- BLINK_FRAMES, 30, frames per blink half-period (>=1).

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- x  in  10  current pixel column.
- y  in  10  current pixel row.
- frame_tick  in  1  one-cycle pulse once per frame.
- wr_valid  in  1  character write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_addr  in  AW  linear cell index row*COLS+col, AW=clog2(COLS*ROWS).
- wr_data  in  8  [6:0] ASCII code, [7] blink attribute.
- clr  in  1  pulse: start buffer clear.
- busy  out  1  clear in progress.
- cur_col  in  clog2(COLS)  cursor column (TEXT_CURSOR_EN only).
- cur_row  in  clog2(ROWS)  cursor row (TEXT_CURSOR_EN only).
- text_on  out  1  current pixel is lit text.
- text_rgb  out  12  FG_RGB when text_on, else 12'h000.

Behaviour:
- Reset values (asynchronous): text_on=0, text_rgb=0, wr_ready=0, busy=1, blink counter=0, blink_phase=0, FSM=CLEAR, clear pointer=0.
- FSM states:
  - CLEAR: writes 8'h00 to cell[ptr] each cycle; ptr++. After writing ptr=COLS*ROWS-1, go to IDLE. Takes exactly COLS*ROWS cycles. busy=1, wr_ready=0.
  - IDLE: busy=0, wr_ready=1. A clr pulse resets ptr to 0 and enters CLEAR on the next edge.
- clr received while in CLEAR is ignored; the clear does not restart.
- In IDLE, clr and wr_valid in the same cycle: the clr wins and the write is not accepted (wr_ready is registered-low from the next cycle; the write in this cycle is dropped and wr_ready must read 0 that cycle).
  - Implement wr_ready = (state==IDLE) && !clr.
- A write with wr_addr >= COLS*ROWS is handshaken and discarded.
- Write and render read to the same cell in the same cycle: the read returns the old data (read-before-write).
- Pixel mapping, with dx=x-ORIGIN_X and dy=y-ORIGIN_Y:
  - col=dx>>(3+SCALE_LOG2), row=dy>>(4+SCALE_LOG2).
  - glyph bit index=(dx>>SCALE_LOG2)[2:0], glyph line=(dy>>SCALE_LOG2)[3:0].
  - In window iff x>=ORIGIN_X, y>=ORIGIN_Y, col<COLS, row<ROWS. Compare on unsigned values before subtracting, so nothing wraps.
- Pipeline, latency 3 cycles from x/y to text_on/text_rgb:
  - S1 registers the buffer read plus in-window flag, bit index and glyph line.
  - S2 drives ascii_rom addr={code[6:0], line} with 1-cycle ROM latency and carries the attribute.
  - S3 selects font bit word[7-bit] and registers the outputs.
- Out-of-window pixels give text_on=0.
- Blink:
  - On frame_tick the counter increments. When it reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - A cell with attribute 1 renders nothing while blink_phase=1.
- ASCII 0x00 renders blank (font row zero).

Optional Feature:
- TEXT_CURSOR_EN defined: the cell at (cur_col, cur_row) shows an underline on glyph lines 14-15 of that cell, ORed with the glyph. The underline is visible while blink_phase=0, and goes through the same 3-stage latency.
- Undefined: cur_col and cur_row are present but ignored; no cursor logic is synthesised.

Test Plan:
- Reset released with COLS=40, ROWS=4 -> busy=1 and wr_ready=0 for exactly 160 cycles, then busy=0, wr_ready=1; every cell renders text_on=0.
- Write addr 0 data 8'h50 ('P') at ORIGIN (0,32), scale 2. Sweep x=0..15, y=32+2*3 -> text_on after 3 cycles matches ascii_rom['P', line 3] with each bit held for 2 pixels; text_rgb=12'hFFF when lit.
- Pixels x<ORIGIN_X, col=40, y=31, and row=4 -> text_on=0; a write to addr 160 -> handshaken, no cell changes.
- Cell written with data 8'hC1 (blinking 'A'), BLINK_FRAMES=2 -> glyph visible for frames 0-1, blank for frames 2-3, visible again for frame 4.
- clr asserted with wr_valid in IDLE -> wr_ready=0 in that cycle and the write is dropped. A second clr mid-clear -> still exactly 160 busy cycles, then all cells are 0.
- With TEXT_CURSOR_EN, cursor at (5,1) -> lines 14-15 of cell (5,1) are lit during blink_phase=0 and unlit during blink_phase=1.
